// File: rtl/awgn_urng_bank.sv
// awgn_urng_bank: multi-channel taus88 uniform source with runtime reseed,
// warm-up discard, ready/valid output and a wrapping transfer counter.
module awgn_urng_bank #(
  parameter int          NUM_CH     = 2,
  parameter int          OUT_W      = 16,
  parameter int          WARMUP     = 4,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] DEF_SEED_A = 32'h00067580,
  parameter logic [31:0] DEF_SEED_B = 32'h00070385
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             seed_a,
  input  logic [31:0]             seed_b,
  input  logic                    seed_load,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]        sample_cnt
);
  typedef enum logic {WARM, RUN} state_t;
  localparam state_t     START = WARMUP == 0 ? RUN : WARM;
  localparam logic [7:0] WLAST = 8'(WARMUP == 0 ? 0 : WARMUP - 1);
  state_t           state_q, state_d;
  logic [7:0]       warm_q, warm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step;
  logic [31:0]      sa, sb;
  assign out_valid  = state_q == RUN;
  assign sample_cnt = cnt_q;
  // a load takes the cycle: no step and no transfer alongside it
  assign step = !seed_load && (state_q == WARM || out_ready);
  assign sa   = reset ? DEF_SEED_A : seed_a;
  assign sb   = reset ? DEF_SEED_B : seed_b;
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cnt_d   = cnt_q;
    if (seed_load) begin
      state_d = START;
      warm_d  = '0;
      cnt_d   = '0;
    end else if (state_q == WARM) begin
      warm_d  = warm_q + 8'd1;
      state_d = warm_q == WLAST ? RUN : WARM;
    end else if (out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START;
      warm_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [31:0] K = 32'(64'h9E3779B9 * 64'(c + 1));
    logic [31:0] s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
    assign s0_d = ((s0_q & 32'hFFFFFFFE) << 12) ^ (((s0_q << 13) ^ s0_q) >> 19);
    assign s1_d = ((s1_q & 32'hFFFFFFF8) << 4)  ^ (((s1_q << 2)  ^ s1_q) >> 25);
    assign s2_d = ((s2_q & 32'hFFFFFFF0) << 17) ^ (((s2_q << 3)  ^ s2_q) >> 11);
    // OR masks keep every component above its taus88 minimum, so zero seeds are safe
    always_ff @(posedge clk) begin
      if (reset || seed_load) begin
        s0_q <= sa | 32'h2;
        s1_q <= sb | 32'h8;
        s2_q <= (sa ^ sb ^ K) | 32'h10;
      end else if (step) begin
        s0_q <= s0_d;
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
    end
    assign out_data[c*OUT_W +: OUT_W] = OUT_W'((s0_q ^ s1_q ^ s2_q) >> (32 - OUT_W));
  end
endmodule

// File: tb/tb_awgn_urng_bank.sv
// tb_awgn_urng_bank: randomized checks of the taus88 bank against a
// behavioural stream model, using default, zero-warm-up and 4-bit-counter builds.
module tb_awgn_urng_bank;
  localparam int          NCH   = 2;
  localparam int          OW    = 16;
  localparam int          DW    = NCH * OW;
  localparam int          WU    = 4;
  localparam logic [31:0] DEF_A = 32'h00067580;
  localparam logic [31:0] DEF_B = 32'h00070385;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, seed_load, out_ready;
  logic [31:0]   seed_a, seed_b;
  logic          ov, ov0, ov4;
  logic [DW-1:0] od, od0, od4;
  logic [31:0]   cnt, cnt0;
  logic [3:0]    cnt4;
  int            checks = 0;
  int            errors = 0;

  awgn_urng_bank #(.NUM_CH(NCH), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset), .seed_a(seed_a), .seed_b(seed_b), .seed_load(seed_load),
    .out_ready(out_ready), .out_valid(ov), .out_data(od), .sample_cnt(cnt));
  awgn_urng_bank #(.NUM_CH(NCH), .OUT_W(OW), .WARMUP(0)) dut_w0 (
    .clk(clk), .reset(reset), .seed_a(seed_a), .seed_b(seed_b), .seed_load(seed_load),
    .out_ready(out_ready), .out_valid(ov0), .out_data(od0), .sample_cnt(cnt0));
  awgn_urng_bank #(.NUM_CH(NCH), .OUT_W(OW), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .seed_a(seed_a), .seed_b(seed_b), .seed_load(seed_load),
    .out_ready(out_ready), .out_valid(ov4), .out_data(od4), .sample_cnt(cnt4));

  // reference generator state, one taus88 triple per channel
  logic [31:0] m0 [NCH];
  logic [31:0] m1 [NCH];
  logic [31:0] m2 [NCH];

  task automatic mseed(input logic [31:0] a, input logic [31:0] b);
    for (int c = 0; c < NCH; c++) begin
      m0[c] = a | 32'h2;
      m1[c] = b | 32'h8;
      m2[c] = (a ^ b ^ (32'h9E3779B9 * 32'(c + 1))) | 32'h10;
    end
  endtask

  task automatic mstep();
    for (int c = 0; c < NCH; c++) begin
      m0[c] = ((m0[c] & 32'hFFFFFFFE) << 12) ^ (((m0[c] << 13) ^ m0[c]) >> 19);
      m1[c] = ((m1[c] & 32'hFFFFFFF8) << 4)  ^ (((m1[c] << 2)  ^ m1[c]) >> 25);
      m2[c] = ((m2[c] & 32'hFFFFFFF0) << 17) ^ (((m2[c] << 3)  ^ m2[c]) >> 11);
    end
  endtask

  function automatic logic [DW-1:0] mout();
    logic [DW-1:0] o;
    for (int c = 0; c < NCH; c++) o[c*OW +: OW] = 16'((m0[c] ^ m1[c] ^ m2[c]) >> 16);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle seed pulse followed by the warm-up steps, model kept in lockstep
  task automatic load(input logic [31:0] a, input logic [31:0] b);
    seed_a = a;
    seed_b = b;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    mseed(a, b);
    repeat (WU) begin
      tick();
      mstep();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mseed(DEF_A, DEF_B);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", ov); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    checks++; if (od !== mout()) begin errors++; $display("FAIL reset_data: got %h expected %h", od, mout()); end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL reset_w0_valid: got %0b expected 1", ov0); end
    for (int i = 1; i < WU; i++) begin
      tick();
      mstep();
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL warm_valid[%0d]: got %0b expected 0", i, ov); end
    end
    tick();
    mstep();
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL warm_rise: got %0b expected 1", ov); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL warm_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      checks++; if (od !== mout()) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", k, od, mout()); end
      checks++; if (cnt !== 32'(k)) begin errors++; $display("FAIL stream_cnt[%0d]: got %0d expected %0d", k, cnt, k); end
      tick();
      mstep();
    end
    checks++; if (cnt !== 32'd1000) begin errors++; $display("FAIL stream_total: got %0d expected 1000", cnt); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL stream_valid: got %0b expected 1", ov); end
  endtask

  task automatic test_warmup0();
    out_ready = 1'b0;
    seed_a = DEF_A;
    seed_b = DEF_B;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    mseed(DEF_A, DEF_B);
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL w0_valid: got %0b expected 1", ov0); end
    checks++; if (od0[15:0] !== 16'h9E37) begin errors++; $display("FAIL w0_ch0: got %h expected 9e37", od0[15:0]); end
    checks++; if (od0 !== mout()) begin errors++; $display("FAIL w0_data: got %h expected %h", od0, mout()); end
    checks++; if (od0[31:16] === 16'h9E37) begin errors++; $display("FAIL w0_ch1_differs: got %h expected not 9e37", od0[31:16]); end
    checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL w0_cnt: got %0d expected 0", cnt0); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL load_drops_valid: got %0b expected 0", ov); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] prev;
    logic          held;
    int            k, low;
    load($urandom, $urandom);
    k = 0;
    low = 0;
    held = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 100 == 50) low = 20;
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b expected 1", cyc, ov); end
      checks++; if (od !== mout()) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", cyc, od, mout()); end
      checks++; if (cnt !== 32'(k)) begin errors++; $display("FAIL bp_cnt[%0d]: got %0d expected %0d", cyc, cnt, k); end
      if (held) begin
        checks++; if (od !== prev) begin errors++; $display("FAIL bp_hold[%0d]: got %h expected %h", cyc, od, prev); end
      end
      out_ready = low > 0 ? 1'b0 : 1'($urandom_range(0, 1));
      if (low > 0) low--;
      prev = od;
      held = !out_ready;
      tick();
      if (out_ready) begin
        mstep();
        k++;
      end
    end
  endtask

  task automatic test_zero_seed();
    int zeros, same;
    out_ready = 1'b1;
    load(32'd0, 32'd0);
    zeros = 0;
    same = 0;
    for (int k = 0; k < 2000; k++) begin
      checks++; if (od !== mout()) begin errors++; $display("FAIL zero_data[%0d]: got %h expected %h", k, od, mout()); end
      if (od[15:0] == 16'd0) zeros++;
      if (od[31:16] == 16'd0) zeros++;
      if (od[15:0] == od[31:16]) same++;
      tick();
      mstep();
    end
    checks++; if (zeros >= 5) begin errors++; $display("FAIL zero_stick: got %0d zero words expected <5", zeros); end
    checks++; if (same >= 5) begin errors++; $display("FAIL zero_ch_same: got %0d equal pairs expected <5", same); end
  endtask

  task automatic test_reload();
    logic [31:0] a, b;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (od !== mout()) begin errors++; $display("FAIL pre_reload[%0d]: got %h expected %h", k, od, mout()); end
      tick();
      mstep();
    end
    a = $urandom;
    b = $urandom;
    seed_a = a;
    seed_b = b;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    mseed(a, b);
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reload_cnt: got %0d expected 0", cnt); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reload_valid: got %0b expected 0", ov); end
    for (int i = 1; i < WU; i++) begin
      tick();
      mstep();
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reload_warm[%0d]: got %0b expected 0", i, ov); end
    end
    tick();
    mstep();
    for (int k = 0; k < 8; k++) begin
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL reload_run_valid[%0d]: got %0b expected 1", k, ov); end
      checks++; if (od !== mout()) begin errors++; $display("FAIL reload_data[%0d]: got %h expected %h", k, od, mout()); end
      tick();
      mstep();
    end
    seed_a = $urandom;
    seed_b = $urandom;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tick();
    tick();
    a = $urandom;
    b = $urandom;
    seed_a = a;
    seed_b = b;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    mseed(a, b);
    for (int i = 1; i < WU; i++) begin
      tick();
      mstep();
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rewarm_valid[%0d]: got %0b expected 0", i, ov); end
    end
    tick();
    mstep();
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL rewarm_rise: got %0b expected 1", ov); end
    checks++; if (od !== mout()) begin errors++; $display("FAIL rewarm_data: got %h expected %h", od, mout()); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    load($urandom, $urandom);
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL wrap_start: got %0d expected 0", cnt4); end
    for (int n = 1; n <= 17; n++) begin
      tick();
      mstep();
      checks++; if (cnt4 !== 4'(n)) begin errors++; $display("FAIL wrap_cnt4[%0d]: got %0d expected %0d", n, cnt4, n % 16); end
      checks++; if (cnt !== 32'(n)) begin errors++; $display("FAIL wrap_cnt32[%0d]: got %0d expected %0d", n, cnt, n); end
    end
    checks++; if (od4 !== mout()) begin errors++; $display("FAIL wrap_data: got %h expected %h", od4, mout()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mseed(DEF_A, DEF_B);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b expected 0", ov); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL midreset_cnt: got %0d expected 0", cnt); end
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL midreset_cnt4: got %0d expected 0", cnt4); end
    checks++; if (od !== mout()) begin errors++; $display("FAIL midreset_data: got %h expected %h", od, mout()); end
  endtask

  initial begin
    reset = 1'b1;
    seed_load = 1'b0;
    out_ready = 1'b0;
    seed_a = '0;
    seed_b = '0;
    test_reset();
    test_stream();
    test_warmup0();
    test_backpressure();
    test_zero_seed();
    test_reload();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
